usb_packet_decoder: RTL and testbench

Parametrised USB receive packet decoder between the UTMI-style receive interface (`rx_data`/`rx_valid`/`rx_active`/`rx_error`) and the device endpoint logic. It validates PIDs, decodes tokens with CRC5 check and device-address filtering, and streams data payloads with the two CRC16 bytes stripped. It reports per-packet status (length, CRC16, errors) at end of packet. It is the successor of the fixed-format decoder inside `usb_controller`, adding configurable payload depth, address filtering and explicit error reporting.

---
 rtl/usb_packet_decoder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_usb_packet_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_decoder.sv
// USB receive packet decoder: PID check, token CRC5/address filter, data holdback.
// Define USB_PKT_CRC16_EN to build the data-packet CRC16 checker.
package types;
  typedef logic [3:0] pid_t;
  localparam pid_t PID_OUT   = 4'h1;
  localparam pid_t PID_IN    = 4'h9;
  localparam pid_t PID_SOF   = 4'h5;
  localparam pid_t PID_SETUP = 4'hD;
  localparam pid_t PID_DATA0 = 4'h3;
  localparam pid_t PID_DATA1 = 4'hB;
endpackage

module usb_packet_decoder
  import types::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       dev_addr,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_active,
  input  logic             rx_error,
  output pid_t             pid,
  output logic             pid_valid,
  output logic [6:0]       address,
  output logic [3:0]       end_point,
  output logic             token_valid,
  output logic [7:0]       data_o,
  output logic             data_valid,
  output logic             data_done,
  output logic             crc16_ok,
  output logic [LEN_W-1:0] length,
  output logic             pkt_error
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD+4);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_PAYLOAD+2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD+3);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2,
    S_TOK_END, S_DATA, S_HS_END, S_DRAIN
  } state_t;

  state_t state_q, state_d, st_c;
  logic act_q, err_c, len_err_c;
  logic tok_c, dat_c;
  pid_t pid_q, pid_d;
  logic pidv_q, pidv_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] ep_q, ep_d;
  logic tokv_q, tokv_d;
  logic [7:0] data_q, data_d;
  logic dv_q, dv_d;
  logic done_q, done_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic perr_q, perr_d;
  logic [7:0] b1_q, b1_d;
  logic [2:0] ephi_q, ephi_d;
  logic [4:0] crc5_q, crc5_d;
  logic extra_q, extra_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0] h0_q, h0_d, h1_q, h1_d;
`ifdef USB_PKT_CRC16_EN
  logic [15:0] crc16_q, crc16_d;
  logic crc_ok_q, crc_ok_d;
`endif

  function automatic logic [4:0] crc5_upd(
    input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 5'h14 : 5'h00);
    return r;
  endfunction

`ifdef USB_PKT_CRC16_EN
  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 16'hA001 : 16'h0000);
    return r;
  endfunction
`endif

  assign tok_c = (rx_data[3:0] == PID_OUT) || (rx_data[3:0] == PID_IN)
              || (rx_data[3:0] == PID_SOF) || (rx_data[3:0] == PID_SETUP);
  assign dat_c = (rx_data[3:0] == PID_DATA0) || (rx_data[3:0] == PID_DATA1);

  always_comb begin
    state_d   = state_q;
    st_c      = state_q;
    err_c     = 1'b0;
    len_err_c = 1'b0;
    pid_d     = pid_q;
    pidv_d    = 1'b0;
    addr_d    = addr_q;
    ep_d      = ep_q;
    tokv_d    = 1'b0;
    data_d    = data_q;
    dv_d      = 1'b0;
    done_d    = 1'b0;
    length_d  = length_q;
    perr_d    = 1'b0;
    b1_d      = b1_q;
    ephi_d    = ephi_q;
    crc5_d    = crc5_q;
    extra_d   = extra_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
`ifdef USB_PKT_CRC16_EN
    crc16_d   = crc16_q;
    crc_ok_d  = crc_ok_q;
`endif
    if (state_q == S_IDLE) begin
      if (rx_active && !act_q) state_d = S_PID;
    end else if (state_q == S_DRAIN) begin
      if (!rx_active) state_d = S_IDLE;
    end else if (rx_error) begin
      perr_d  = 1'b1;
      state_d = rx_active ? S_DRAIN : S_IDLE;
    end else begin
      // A byte arriving with the rx_active fall is consumed before EOP.
      if (rx_valid) begin
        unique case (state_q)
          S_PID: begin
            if (rx_data[7:4] == ~rx_data[3:0]) begin
              pid_d   = rx_data[3:0];
              pidv_d  = 1'b1;
              cnt_d   = '0;
              len_d   = '0;
              crc5_d  = 5'h1F;
              extra_d = 1'b0;
              h0_d    = '0;
              h1_d    = '0;
`ifdef USB_PKT_CRC16_EN
              crc16_d = 16'hFFFF;
`endif
              unique case (1'b1)
                tok_c:   st_c = S_TOK1;
                dat_c:   st_c = S_DATA;
                default: st_c = S_HS_END;
              endcase
            end else begin
              err_c = 1'b1;
            end
          end
          S_TOK1: begin
            b1_d   = rx_data;
            crc5_d = crc5_upd(crc5_q, rx_data);
            st_c   = S_TOK2;
          end
          S_TOK2: begin
            ephi_d = rx_data[2:0];
            crc5_d = crc5_upd(crc5_q, rx_data);
            st_c   = S_TOK_END;
          end
          S_TOK_END: extra_d = 1'b1;
          S_DATA: begin
            // Holdback: the byte two places back is released now.
            if (cnt_q >= CNT_MIN && cnt_q < CNT_LIM) begin
              dv_d   = 1'b1;
              data_d = h0_q;
              len_d  = len_q + LEN_W'(1);
            end
            h0_d = h1_q;
            h1_d = rx_data;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`ifdef USB_PKT_CRC16_EN
            crc16_d = crc16_upd(crc16_q, rx_data);
`endif
          end
          S_HS_END: err_c = 1'b1;
          default: ;
        endcase
      end
      if (err_c) begin
        perr_d  = 1'b1;
        state_d = rx_active ? S_DRAIN : S_IDLE;
      end else if (!rx_active) begin
        state_d = S_IDLE;
        unique case (st_c)
          S_TOK1, S_TOK2: perr_d = 1'b1;
          S_TOK_END: begin
            if (extra_d || crc5_d != 5'b00110) begin
              perr_d = 1'b1;
            end else if (b1_d[6:0] == dev_addr || pid_d == PID_SOF) begin
              tokv_d = 1'b1;
              addr_d = b1_d[6:0];
              ep_d   = {ephi_d, b1_d[7]};
            end
          end
          S_DATA: begin
            len_err_c = (cnt_d < CNT_MIN) || (cnt_d > CNT_LIM);
            done_d    = 1'b1;
            length_d  = len_d;
            perr_d    = len_err_c;
`ifdef USB_PKT_CRC16_EN
            crc_ok_d  = !len_err_c && (crc16_d == 16'hB001);
`endif
          end
          default: ;
        endcase
      end else begin
        state_d = st_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      act_q    <= 1'b1;
      pid_q    <= 4'h0;
      pidv_q   <= 1'b0;
      addr_q   <= '0;
      ep_q     <= '0;
      tokv_q   <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      length_q <= '0;
      perr_q   <= 1'b0;
      b1_q     <= '0;
      ephi_q   <= '0;
      crc5_q   <= 5'h1F;
      extra_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      h0_q     <= '0;
      h1_q     <= '0;
`ifdef USB_PKT_CRC16_EN
      crc16_q  <= 16'hFFFF;
      crc_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      act_q    <= rx_active;
      pid_q    <= pid_d;
      pidv_q   <= pidv_d;
      addr_q   <= addr_d;
      ep_q     <= ep_d;
      tokv_q   <= tokv_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      done_q   <= done_d;
      length_q <= length_d;
      perr_q   <= perr_d;
      b1_q     <= b1_d;
      ephi_q   <= ephi_d;
      crc5_q   <= crc5_d;
      extra_q  <= extra_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
`ifdef USB_PKT_CRC16_EN
      crc16_q  <= crc16_d;
      crc_ok_q <= crc_ok_d;
`endif
    end
  end

  assign pid         = pid_q;
  assign pid_valid   = pidv_q;
  assign address     = addr_q;
  assign end_point   = ep_q;
  assign token_valid = tokv_q;
  assign data_o      = data_q;
  assign data_valid  = dv_q;
  assign data_done   = done_q;
  assign length      = length_q;
  assign pkt_error   = perr_q;
`ifdef USB_PKT_CRC16_EN
  assign crc16_ok    = crc_ok_q;
`else
  assign crc16_ok    = 1'b1;
`endif

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Scoreboard bench for usb_packet_decoder: directed packets, expected
// output events queued at stimulus time and popped by a negedge monitor.
module tb_usb_packet_decoder;
  import types::*;

  localparam int MAXP = 8;
  localparam int LW   = $clog2(MAXP+1);
`ifdef USB_PKT_CRC16_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam logic BAD_OK = CRC_EN ? 1'b0 : 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    dev_addr = 7'h15;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_active = 1'b0;
  logic          rx_error = 1'b0;
  pid_t          pid;
  logic          pid_valid, token_valid, data_valid;
  logic          data_done, crc16_ok, pkt_error;
  logic [6:0]    address;
  logic [3:0]    end_point;
  logic [7:0]    data_o;
  logic [LW-1:0] length;

  usb_packet_decoder #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .reset(reset), .dev_addr(dev_addr),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_error(rx_error),
    .pid(pid), .pid_valid(pid_valid),
    .address(address), .end_point(end_point),
    .token_valid(token_valid), .data_o(data_o),
    .data_valid(data_valid), .data_done(data_done),
    .crc16_ok(crc16_ok), .length(length),
    .pkt_error(pkt_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pv; logic [3:0] pid;
    logic tv; logic [6:0] ad; logic [3:0] ep;
    logic dv; logic [7:0] d;
    logic dn; logic [LW-1:0] len; logic ok;
    logic pe;
  } ev_t;

  ev_t   sb[$];
  string tq[$];
  logic [7:0] tx[$];
  int nvec = 0;
  int nerr = 0;

  function automatic ev_t e_pid(input logic [3:0] p);
    ev_t e = '0; e.pv = 1'b1; e.pid = p; return e;
  endfunction
  function automatic ev_t e_tok(input logic [6:0] a, input logic [3:0] ep);
    ev_t e = '0; e.tv = 1'b1; e.ad = a; e.ep = ep; return e;
  endfunction
  function automatic ev_t e_dat(input logic [7:0] d);
    ev_t e = '0; e.dv = 1'b1; e.d = d; return e;
  endfunction
  function automatic ev_t e_done(input int len, input logic ok, input logic pe);
    ev_t e = '0; e.dn = 1'b1; e.len = LW'(len); e.ok = ok; e.pe = pe; return e;
  endfunction
  function automatic ev_t e_err();
    ev_t e = '0; e.pe = 1'b1; return e;
  endfunction

  task automatic ex(input ev_t e, input string n);
    sb.push_back(e);
    tq.push_back(n);
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  function automatic ev_t obs();
    ev_t o = '0;
    if (pid_valid) begin o.pv = 1'b1; o.pid = pid; end
    if (token_valid) begin o.tv = 1'b1; o.ad = address; o.ep = end_point; end
    if (data_valid) begin o.dv = 1'b1; o.d = data_o; end
    if (data_done) begin o.dn = 1'b1; o.len = length; o.ok = crc16_ok; end
    o.pe = pkt_error;
    return o;
  endfunction

  always @(negedge clk) begin
    ev_t o, x;
    string n;
    if (!reset) begin
      o = obs();
      if (o != '0) begin
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected event: got %h, required none", o);
        end else begin
          x = sb.pop_front();
          n = tq.pop_front();
          if (o !== x) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", n, o, x);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit eop);
    rx_data  = b;
    rx_valid = 1'b1;
    if (eop) rx_active = 1'b0;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pkt(input bit same, input int gap);
    rx_active = 1'b1;
    tick();
    tick();
    for (int i = 0; i < tx.size(); i++)
      send(tx[i], same && (i == tx.size() - 1));
    rx_active = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic mk_tok(input logic [7:0] pb, input logic [6:0] a, input logic [3:0] ep);
    logic [10:0] v;
    logic [4:0] c;
    logic fb;
    v = {ep, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[0] ^ v[i];
      c  = c >> 1;
      if (fb) c = c ^ 5'h14;
    end
    tx.delete();
    tx.push_back(pb);
    tx.push_back({ep[0], a});
    tx.push_back({~c, ep[3:1]});
  endtask

  task automatic add_crc16();
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 1; i < tx.size(); i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ tx[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    c = ~c;
    tx.push_back(c[7:0]);
    tx.push_back(c[15:8]);
  endtask

  task automatic chk_reset(input string n);
    chk({n, " pid"},         16'(pid),         16'h0);
    chk({n, " address"},     16'(address),     16'h0);
    chk({n, " end_point"},   16'(end_point),   16'h0);
    chk({n, " data_o"},      16'(data_o),      16'h0);
    chk({n, " length"},      16'(length),      16'h0);
    chk({n, " crc16_ok"},    16'(crc16_ok),    16'(BAD_OK));
    chk({n, " pulses"},
        16'({pid_valid, token_valid, data_valid, data_done, pkt_error}),
        16'h0);
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk_reset("reset");
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // SETUP to this device
    mk_tok(8'h2D, 7'h15, 4'hE);
    ex(e_pid(4'hD), "setup pid");
    ex(e_tok(7'h15, 4'hE), "setup token");
    pkt(1'b0, 2);

    // OUT to another device: filtered silently
    mk_tok(8'hE1, 7'h3A, 4'hA);
    ex(e_pid(4'h1), "out pid");
    pkt(1'b0, 2);

    // same token, CRC5 corrupted
    mk_tok(8'hE1, 7'h3A, 4'hA);
    tx[2] = tx[2] ^ 8'h80;
    ex(e_pid(4'h1), "crc5 pid");
    ex(e_err(), "crc5 error");
    pkt(1'b0, 2);

    // SOF bypasses the address filter
    mk_tok(8'hA5, 7'h25, 4'h7);
    ex(e_pid(4'h5), "sof pid");
    ex(e_tok(7'h25, 4'h7), "sof token");
    pkt(1'b0, 2);

    // last byte coincides with the rx_active fall
    mk_tok(8'h2D, 7'h15, 4'hE);
    ex(e_pid(4'hD), "same-cycle pid");
    ex(e_tok(7'h15, 4'hE), "same-cycle token");
    pkt(1'b1, 2);

    // token one byte short
    mk_tok(8'h2D, 7'h15, 4'hE);
    void'(tx.pop_back());
    ex(e_pid(4'hD), "short pid");
    ex(e_err(), "short token error");
    pkt(1'b0, 1);

    // DATA0 with good CRC, back-to-back with one idle cycle
    tx.delete();
    tx.push_back(8'hC3);
    for (int i = 0; i < 4; i++) tx.push_back(8'(i));
    add_crc16();
    ex(e_pid(4'h3), "data0 pid");
    for (int i = 0; i < 4; i++) ex(e_dat(8'(i)), "data0 byte");
    ex(e_done(4, 1'b1, 1'b0), "data0 done");
    pkt(1'b0, 1);

    // DATA1 with last CRC byte corrupted
    tx.delete();
    tx.push_back(8'h4B);
    tx.push_back(8'h23);
    tx.push_back(8'h45);
    tx.push_back(8'h67);
    tx.push_back(8'h89);
    add_crc16();
    tx[tx.size()-1] = tx[tx.size()-1] ^ 8'h01;
    ex(e_pid(4'hB), "data1 pid");
    ex(e_dat(8'h23), "data1 byte");
    ex(e_dat(8'h45), "data1 byte");
    ex(e_dat(8'h67), "data1 byte");
    ex(e_dat(8'h89), "data1 byte");
    ex(e_done(4, BAD_OK, 1'b0), "data1 done");
    pkt(1'b0, 2);

    // 11 bytes after PID overflows an 8-byte payload
    tx.delete();
    tx.push_back(8'hC3);
    for (int i = 0; i < 11; i++) tx.push_back(8'(8'h10 + i));
    ex(e_pid(4'h3), "ovf pid");
    for (int i = 0; i < 8; i++) ex(e_dat(8'(8'h10 + i)), "ovf byte");
    ex(e_done(8, BAD_OK, 1'b1), "ovf done");
    pkt(1'b0, 2);

    // zero-length payload: CRC bytes only
    tx.delete();
    tx.push_back(8'hC3);
    add_crc16();
    ex(e_pid(4'h3), "zlp pid");
    ex(e_done(0, 1'b1, 1'b0), "zlp done");
    pkt(1'b0, 2);

    // one byte after PID is too short
    tx.delete();
    tx.push_back(8'h4B);
    tx.push_back(8'h5A);
    ex(e_pid(4'hB), "runt pid");
    ex(e_done(0, BAD_OK, 1'b1), "runt done");
    pkt(1'b0, 2);

    // 8'hD2 is ACK (D = ~2)
    tx.delete();
    tx.push_back(8'hD2);
    ex(e_pid(4'h2), "ack pid");
    pkt(1'b0, 2);

    // handshake followed by a stray byte
    tx.push_back(8'h00);
    ex(e_pid(4'h2), "hs pid");
    ex(e_err(), "hs extra error");
    pkt(1'b0, 2);

    // non-complementary PID nibbles
    tx.delete();
    tx.push_back(8'hD3);
    ex(e_err(), "bad pid error");
    pkt(1'b0, 2);

    // rx_error in the middle of a data packet
    ex(e_pid(4'h3), "rxerr pid");
    ex(e_dat(8'hAA), "rxerr byte");
    ex(e_err(), "rxerr error");
    rx_active = 1'b1;
    tick();
    tick();
    send(8'hC3, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    send(8'hDD, 1'b0);
    rx_active = 1'b0;
    repeat (2) tick();

    // reset in the middle of a data packet
    ex(e_pid(4'h3), "rst pid");
    ex(e_dat(8'h11), "rst byte");
    rx_active = 1'b1;
    tick();
    tick();
    send(8'hC3, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk_reset("mid reset");
    tick();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rx_active = 1'b0;
    repeat (2) tick();
    tx.delete();
    tx.push_back(8'hD2);
    ex(e_pid(4'h2), "post-reset pid");
    pkt(1'b0, 4);

    @(negedge clk);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL missing events: got %0d left, required 0 (next %s)",
               sb.size(), tq[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
